// File: rtl/multi_score_controller.sv
// ---------------------------------------------------------------------------
// multi_score_controller
//   Score keeper and game-flow FSM for up to eight players.
//   States: IDLE -> PLAY -> (HOLD -> PLAY)* -> OVER.
//   A PLAY cycle accepts at most one point, taking the lowest-index set bit.
//   HOLD ignores points until HOLDOFF_FRAMES frame_start pulses have passed.
//
// Configuration macro:
//   SCORE_DEUCE_EN  defined   : win needs score >= WIN_SCORE and a lead of
//                               at least 2 over every other player
//                   undefined : first player to reach WIN_SCORE wins
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   game_start   start/restart pulse; beats any point/frame_start in the same cycle
//   frame_start  one pulse per video frame, counted only in HOLD
//   point        bit i pulses when player i earns a point
//   score_flat   player i score at [i*SCORE_W +: SCORE_W]
//   point_ack    one-hot pulse for the accepted point
//   game_state   0=IDLE 1=PLAY 2=HOLD 3=OVER
//   game_over    high while in OVER
//   winner       winning player index while game_over is high, else 0
// ---------------------------------------------------------------------------
module multi_score_controller #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned WIN_SCORE      = 11,
    parameter int unsigned HOLDOFF_FRAMES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           game_start,
    input  logic                           frame_start,
    input  logic [NUM_PLAYERS-1:0]         point,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat,
    output logic [NUM_PLAYERS-1:0]         point_ack,
    output logic [1:0]                     game_state,
    output logic                           game_over,
    output logic [2:0]                     winner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [7:0]         HOLD_LAST = 8'(HOLDOFF_FRAMES - 1);

    state_t                 state_q, state_d;
    logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [NUM_PLAYERS-1:0] ack_d;
    logic [2:0]             winner_d;

    logic [NUM_PLAYERS-1:0] sel_oh;
    logic [2:0]             sel_idx;
    logic [SCORE_W-1:0]     sel_new;
    logic                   win_hit;

    // Lowest-index point wins; its saturated incremented score feeds the win check.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        sel_new = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (point[i] && (sel_oh == '0)) begin
                sel_oh[i] = 1'b1;
                sel_idx   = 3'(i);
                sel_new   = (score_q[i] == SCORE_MAX) ? score_q[i]
                                                      : score_q[i] + SCORE_W'(1);
            end
        end
    end

`ifdef SCORE_DEUCE_EN
    localparam logic [SCORE_W:0] LEAD = (SCORE_W+1)'(2);

    // Widened by one bit so other-score + 2 cannot wrap near saturation.
    always_comb begin
        win_hit = (sel_new >= WIN_VAL);
        for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
            if (!sel_oh[j] && ({1'b0, sel_new} < ({1'b0, score_q[j]} + LEAD)))
                win_hit = 1'b0;
        end
    end
`else
    always_comb begin
        win_hit = (sel_new == WIN_VAL);
    end
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        winner_d    = winner;
        ack_d       = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++)
            score_d[i] = score_q[i];

        if (game_start) begin
            state_d     = PLAY;
            frame_cnt_d = '0;
            winner_d    = '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                score_d[i] = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                PLAY: begin
                    if (|sel_oh) begin
                        for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                            if (sel_oh[i]) score_d[i] = sel_new;
                        ack_d = sel_oh;
                        // Clearing here means a frame_start in the accepting
                        // cycle never counts toward the holdoff.
                        frame_cnt_d = '0;
                        if (win_hit) begin
                            state_d  = OVER;
                            winner_d = sel_idx;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (frame_start) begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = PLAY;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                OVER: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            point_ack   <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                score_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            point_ack   <= ack_d;
            game_over   <= (state_d == OVER);
            winner      <= winner_d;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                score_q[i] <= score_d[i];
        end
    end

    assign game_state = state_q;

    always_comb begin
        score_flat = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++)
            score_flat[i*SCORE_W +: SCORE_W] = score_q[i];
    end

endmodule

// File: tb/tb_multi_score_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_score_controller
//   Directed bench for multi_score_controller with default parameters.
//   A behavioural game model produces the expected outputs for each driven
//   step; they are queued and compared once the clock edge has happened.
//   Builds with or without SCORE_DEUCE_EN.
// ---------------------------------------------------------------------------
module tb_multi_score_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_start;
    logic        frame_start;
    logic [1:0]  point;
    logic [15:0] score_flat;
    logic [1:0]  point_ack;
    logic [1:0]  game_state;
    logic        game_over;
    logic [2:0]  winner;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] score;
        logic [1:0]  ack;
        logic [1:0]  st;
        logic        over;
        logic [2:0]  win;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    // behavioural game model
    int         m_state;
    int         m_cnt;
    int         m_win;
    int         m_s[2];
    logic [1:0] m_ack;

    multi_score_controller #(
        .NUM_PLAYERS    (2),
        .SCORE_W        (8),
        .WIN_SCORE      (11),
        .HOLDOFF_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_start  (game_start),
        .frame_start (frame_start),
        .point       (point),
        .score_flat  (score_flat),
        .point_ack   (point_ack),
        .game_state  (game_state),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_win = 0;
        m_s[0] = 0;  m_s[1] = 0;
        m_ack = 2'b00;
    endtask

    task automatic model_apply(input logic gs, input logic fs, input logic [1:0] pt);
        int p;
        int o;
        bit won;
        m_ack = 2'b00;
        if (gs) begin
            m_state = 1; m_cnt = 0; m_win = 0;
            m_s[0] = 0;  m_s[1] = 0;
        end else if (m_state == 1 && pt != 2'b00) begin
            p = pt[0] ? 0 : 1;
            o = 1 - p;
            if (m_s[p] < 255) m_s[p] = m_s[p] + 1;
            m_ack = (p == 0) ? 2'b01 : 2'b10;
`ifdef SCORE_DEUCE_EN
            won = (m_s[p] >= 11) && (m_s[p] - m_s[o] >= 2);
`else
            won = (m_s[p] == 11);
`endif
            if (won) begin
                m_state = 3; m_win = p;
            end else begin
                m_state = 2; m_cnt = 0;
            end
        end else if (m_state == 2 && fs) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 2) begin
                m_state = 1; m_cnt = 0;
            end
        end
    endtask

    task automatic push_expect(input string tag);
        exp_t e;
        e.score = {8'(m_s[1]), 8'(m_s[0])};
        e.ack   = m_ack;
        e.st    = 2'(m_state);
        e.over  = (m_state == 3);
        e.win   = (m_state == 3) ? 3'(m_win) : 3'd0;
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string tag;
        e   = sb.pop_front();
        tag = tq.pop_front();
        total++;
        assert (score_flat === e.score) else begin
            bad++;
            $error("FAIL %s score_flat observed=%0h expected=%0h", tag, score_flat, e.score);
        end
        total++;
        assert (point_ack === e.ack) else begin
            bad++;
            $error("FAIL %s point_ack observed=%0b expected=%0b", tag, point_ack, e.ack);
        end
        total++;
        assert (game_state === e.st) else begin
            bad++;
            $error("FAIL %s game_state observed=%0d expected=%0d", tag, game_state, e.st);
        end
        total++;
        assert (game_over === e.over) else begin
            bad++;
            $error("FAIL %s game_over observed=%0b expected=%0b", tag, game_over, e.over);
        end
        total++;
        assert (winner === e.win) else begin
            bad++;
            $error("FAIL %s winner observed=%0d expected=%0d", tag, winner, e.win);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check after the rising edge.
    task automatic step(input string tag, input logic gs, input logic fs, input logic [1:0] pt);
        @(negedge clk);
        game_start  = gs;
        frame_start = fs;
        point       = pt;
        model_apply(gs, fs, pt);
        push_expect(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // One point for player p, then frame pulses until play resumes (if not over).
    task automatic score_pt(input string tag, input int p);
        int guard;
        step(tag, 1'b0, 1'b0, (p == 0) ? 2'b01 : 2'b10);
        guard = 0;
        while (m_state == 2 && guard < 8) begin
            step("holdoff", 1'b0, 1'b1, 2'b00);
            guard++;
        end
    endtask

    initial begin
        reset = 1'b0; game_start = 1'b0; frame_start = 1'b0; point = 2'b00;
        model_reset();
        #2;
        push_expect("reset_init");
        check_out();
        @(negedge clk);
        reset = 1'b1;

        step("idle_hold",     1'b0, 1'b0, 2'b00);
        step("idle_point",    1'b0, 1'b0, 2'b01);
        step("start",         1'b1, 1'b0, 2'b00);
        step("first_point",   1'b0, 1'b0, 2'b01);
        step("hold_f1",       1'b0, 1'b1, 2'b10);
        step("hold_nof",      1'b0, 1'b0, 2'b10);
        step("hold_f2",       1'b0, 1'b1, 2'b10);
        step("simul_points",  1'b0, 1'b1, 2'b11);
        step("entry_f_1",     1'b0, 1'b1, 2'b00);
        step("entry_f_2",     1'b0, 1'b1, 2'b00);
        step("p1_point",      1'b0, 1'b0, 2'b10);
        step("restart_hold",  1'b1, 1'b1, 2'b01);
        step("play_point_gs", 1'b1, 1'b0, 2'b01);

        for (int i = 0; i < 11; i++) score_pt("p1_run", 1);
        step("over_pt0",      1'b0, 1'b0, 2'b01);
        step("over_pt1",      1'b0, 1'b1, 2'b10);
        step("restart_over",  1'b1, 1'b0, 2'b00);

        for (int i = 0; i < 10; i++) begin
            score_pt("tie_p0", 0);
            score_pt("tie_p1", 1);
        end
        score_pt("p0_to_11", 0);
        if (m_state != 3) score_pt("p0_to_12", 0);
        step("final_ignore",  1'b0, 1'b0, 2'b10);

        step("restart_b",     1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) score_pt("b_p1", 1);
        for (int i = 0; i < 4; i++) score_pt("b_p0", 0);
        step("b_last_pt",     1'b0, 1'b0, 2'b01);

        // asynchronous reset in the middle of the HOLD cycle
        @(negedge clk);
        game_start = 1'b0; frame_start = 1'b0; point = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        push_expect("async_reset");
        check_out();
        @(posedge clk);
        #1;
        push_expect("reset_held");
        check_out();
        @(negedge clk);
        reset = 1'b1;
        step("first_edge",    1'b1, 1'b0, 2'b00);
        step("after_rst_pt",  1'b0, 1'b0, 2'b10);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_score_controller.md
MULTI_SCORE_CONTROLLER -- requirements
Module: multi_score_controller

Interface
- REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of scoring channels; legal range 2..8.
- REQ-002 SHALL have parameter SCORE_W, default 8, width of each score counter.
- REQ-003 SHALL have parameter WIN_SCORE, default 11, score that ends the game; must be less than 2^SCORE_W.
- REQ-004 SHALL have parameter HOLDOFF_FRAMES, default 2, frame_start pulses ignored after each point; legal range 1..255.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock.
- REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port game_start, input, 1 bit: debounced single-cycle start/restart pulse.
- REQ-008 SHALL have port frame_start, input, 1 bit: single-cycle pulse once per video frame.
- REQ-009 SHALL have port point, input, NUM_PLAYERS bits: bit i pulses when player i earns a point.
- REQ-010 SHALL have port score_flat, output, NUM_PLAYERS*SCORE_W bits: player i's score in bits [i*SCORE_W +: SCORE_W].
- REQ-011 SHALL have port point_ack, output, NUM_PLAYERS bits: one-hot, single-cycle, marks the point accepted.
- REQ-012 SHALL have port game_state, output, 2 bits: 0=IDLE, 1=PLAY, 2=HOLD, 3=OVER.
- REQ-013 SHALL have port game_over, output, 1 bit: high while in OVER.
- REQ-014 SHALL have port winner, output, 3 bits: index of the winning player; valid while game_over is high.

Function
- REQ-015 SHALL be a registered FSM with states IDLE, PLAY, HOLD, OVER; all outputs registered.
- REQ-016 IDLE: scores held at 0; game_start moves to PLAY on the next cycle.
- REQ-017 PLAY: any set bit in point is accepted; on simultaneous bits, the lowest index wins and the others are dropped with no ack.
- REQ-018 An accepted point SHALL increment that player's score and pulse its point_ack bit, both in the cycle after sampling (latency 1).
- REQ-019 Score SHALL saturate at 2^SCORE_W-1 and never wrap.
- REQ-020 After an accepted point: if the win condition holds for the incremented score, go to OVER and latch winner; otherwise go to HOLD with the frame counter cleared.
- REQ-021 HOLD: point inputs ignored; counter increments on each frame_start; on the HOLDOFF_FRAMES-th pulse, return to PLAY.
- REQ-022 A frame_start coincident with the HOLD entry cycle SHALL not be counted.
- REQ-023 OVER: scores and winner frozen; point ignored; game_over=1.
- REQ-024 game_start in PLAY, HOLD or OVER SHALL clear all scores, the counter and winner, and enter PLAY next cycle.
- REQ-025 game_start has priority over a simultaneous point or frame_start.
- REQ-026 winner SHALL read 0 when game_over is low.

Reset
- REQ-027 Asserted reset SHALL immediately force IDLE, all scores 0, point_ack 0, game_over 0, winner 0, game_state 0, and the frame counter 0, including mid-game.
- REQ-028 After reset release, the first active clock edge SHALL evaluate inputs normally.

Configuration
- REQ-029 Macro SCORE_DEUCE_EN: when defined, the win condition is score >= WIN_SCORE and a lead of at least 2 over every other player.
- REQ-030 When SCORE_DEUCE_EN is not defined, the win condition is score == WIN_SCORE; the first player to reach it wins.

Verification
- REQ-031 Default params, reset, game_start, then point=01 -> next cycle score0=1, point_ack=01, game_state=HOLD.
- REQ-032 In HOLD, point=10 plus 2 frame_start pulses -> score1 stays 0, no ack, PLAY after the 2nd pulse.
- REQ-033 In PLAY, point=11 -> only score0 increments, point_ack=01.
- REQ-034 Without the macro, drive player1 to 11 points -> game_over=1, winner=1, game_state=3; further points are ignored.
- REQ-035 With SCORE_DEUCE_EN, scores reach 10-10, then player0 scores -> 11-10 and no OVER; player0 scores again -> 12-10, OVER, winner=0.
- REQ-036 Assert reset while in HOLD with scores 5-3 -> all outputs 0 and IDLE immediately; game_start in OVER -> scores 0 and PLAY the next cycle.
